// File: rtl/ro_scan_counter.sv
// Ring-oscillator scan counter.
// Steps the RO mux select through all N oscillators. Each oscillator gets a settle
// window, then a gate window of GATE_CYCLES clk cycles in which rising edges of the
// synchronised mux output are counted. Each count is reported with its RO index.
module ro_scan_counter #(
    parameter int N             = 8,
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    localparam int SEL_W        = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_selected,
    output logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] cnt_out,
    output logic [SEL_W-1:0] cnt_idx,
    output logic             cnt_valid,
    output logic             busy,
    output logic             done
);

    // One timer serves both the settle and the gate window, so size it for the longer one.
    localparam int TIMER_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST    = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        REPORT,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [SEL_W-1:0]   sel_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [CNT_W-1:0]   counter, counter_next;

    logic s1, s2, s3;
    logic rise;

    // Synchronise the asynchronous RO output and keep one delayed copy for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // values from before the clock edge; blocking here would collapse s1/s2/s3 into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ro_selected;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A rising edge of the RO, as seen after the synchroniser, lasts exactly one clk cycle.
    assign rise = s2 & ~s3;

    // Next-state logic: scan sequencing, window timing and saturating edge counting.
    // NOTE: every signal gets a default before the case statement, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        sel_next     = sel;
        timer_next   = timer;
        counter_next = counter;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = SETTLE;
                    sel_next     = '0;
                    timer_next   = '0;
                    counter_next = '0;
                end
            end
            SETTLE: begin
                // Glitches from the mux switching land here and are discarded.
                counter_next = '0;
                if (timer == SETTLE_LAST) begin
                    state_next = GATE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            GATE: begin
                if (rise && (counter != CNT_MAX)) begin
                    counter_next = counter + 1'b1;
                end
                if (timer == GATE_LAST) begin
                    state_next = REPORT;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            REPORT: begin
                if (sel == SEL_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next   = SETTLE;
                    sel_next     = sel + 1'b1;
                    counter_next = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered outputs, derived from the next state so that each
    // strobe coincides with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            timer     <= '0;
            counter   <= '0;
            cnt_out   <= '0;
            cnt_idx   <= '0;
            cnt_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            timer     <= timer_next;
            counter   <= counter_next;
            cnt_valid <= (state_next == REPORT);
            done      <= (state_next == DONE);
            busy      <= (state_next == SETTLE) || (state_next == GATE) ||
                         (state_next == REPORT);
            // The count includes an edge arriving on the last gate cycle.
            if (state_next == REPORT) begin
                cnt_out <= counter_next;
                cnt_idx <= sel;
            end
        end
    end

endmodule

// File: tb/tb_ro_scan_counter.sv
// Self-checking bench for ro_scan_counter: scan-timing model plus per-index count ranges.
module tb_ro_scan_counter;

    localparam int N      = 8;
    localparam int G      = 100;
    localparam int S      = 4;
    localparam int L      = S + G + 1;        // cycles per oscillator
    localparam int K_DONE = N * L + 1;        // done cycle, counted from the start edge

    logic       clk;
    logic       rst;
    logic       start;
    logic       ro_sel;
    logic       ro_small;
    logic [1:0] mode;

    logic [2:0]  sel, cnt_idx, sel2, cnt_idx2;
    logic [15:0] cnt_out;
    logic [3:0]  cnt_out2;
    logic        cnt_valid, busy, done, cnt_valid2, busy2, done2;

    ro_scan_counter #(.N(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_selected(ro_sel),
        .sel(sel), .cnt_out(cnt_out), .cnt_idx(cnt_idx),
        .cnt_valid(cnt_valid), .busy(busy), .done(done)
    );

    ro_scan_counter #(.N(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .ro_selected(ro_small),
        .sel(sel2), .cnt_out(cnt_out2), .cnt_idx(cnt_idx2),
        .cnt_valid(cnt_valid2), .busy(busy2), .done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator bank: RO i has a period of 4+2i clk cycles, phase not aligned to clk.
    logic ro_bank [N];
    logic ro_fast;
    for (genvar g = 0; g < N; g++) begin : g_ro
        initial begin
            ro_bank[g] = 1'b0;
            #(2 + g % 2);
            forever #((2 + g) * 10) ro_bank[g] = ~ro_bank[g];
        end
    end

    // clk/2 oscillator for the aliasing boundary.
    initial begin
        ro_fast = 1'b0;
        #2;
        forever #10 ro_fast = ~ro_fast;
    end

    // Period-4 oscillator feeding the 4-bit counter instance.
    initial begin
        ro_small = 1'b0;
        #3;
        forever #20 ro_small = ~ro_small;
    end

    // Bench-side mux: selected RO, tied 0, tied 1 or the clk/2 source.
    always_comb begin
        case (mode)
            2'd0:    ro_sel = ro_bank[sel];
            2'd1:    ro_sel = 1'b0;
            2'd2:    ro_sel = 1'b1;
            default: ro_sel = ro_fast;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
        n_checks++;
        if ((^act === 1'bx) || (act < lo) || (act > hi)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Scan model: position within the scan, counted in cycles after the start edge.
    logic m_active = 1'b0;
    int   m_k      = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (m_k == K_DONE) m_active = 1'b0;
            else m_k++;
        end else if (start) begin
            m_active = 1'b1;
            m_k      = 1;
        end
    end

    int exp_lo [N];
    int exp_hi [N];
    logic chk_en = 1'b0;
    int tot_strobes  = 0;
    int tot_dones    = 0;
    int tot_strobes2 = 0;
    int done_k       = 0;
    int first_cnt    = 0;

    int   e_idx, e_ph;
    logic e_in_scan, e_valid, e_done;

    // Compare process: every cycle, DUT outputs against the scan model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_in_scan = m_active && (m_k <= N * L);
            e_idx     = (m_k - 1) / L;
            e_ph      = (m_k - 1) % L;
            e_valid   = e_in_scan && (e_ph == L - 1);
            e_done    = m_active && (m_k == K_DONE);
            check("busy", 32'(busy), 32'(e_in_scan), 32'(e_in_scan));
            check("cnt_valid", 32'(cnt_valid), 32'(e_valid), 32'(e_valid));
            check("done", 32'(done), 32'(e_done), 32'(e_done));
            check("sat_cnt_valid", 32'(cnt_valid2), 32'(e_valid), 32'(e_valid));
            if (m_active) begin
                if (e_in_scan) check("sel", 32'(sel), e_idx, e_idx);
                else check("sel_done", 32'(sel), N - 1, N - 1);
            end
            if (e_in_scan && (e_ph < S)) check("settle_counter", 32'(dut.counter), 0, 0);
            if (cnt_valid) begin
                tot_strobes++;
                if (e_valid) begin
                    check("cnt_idx", 32'(cnt_idx), e_idx, e_idx);
                    check("cnt_out", 32'(cnt_out), exp_lo[e_idx], exp_hi[e_idx]);
                    if (e_idx == 0) first_cnt = int'(cnt_out);
                end
            end
            if (cnt_valid2) begin
                tot_strobes2++;
                check("sat_cnt_out", 32'(cnt_out2), 15, 15);
            end
            if (done) begin
                tot_dones++;
                done_k = m_k;
            end
        end
    end

    int s0, d0, s20;

    task automatic snap();
        s0  = tot_strobes;
        d0  = tot_dones;
        s20 = tot_strobes2;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_scan(input string name);
        snap();
        done_k = 0;
        pulse_start();
        repeat (K_DONE + 4) @(negedge clk);
        check({name, "_strobes"}, tot_strobes - s0, 8, 8);
        check({name, "_dones"}, tot_dones - d0, 1, 1);
        check({name, "_sat_strobes"}, tot_strobes2 - s20, 8, 8);
        check({name, "_done_cycle"}, done_k, 841, 841);
    endtask

    // Wait at negedges until the model reaches cycle tgt, bounded.
    task automatic wait_k(input string name, input int tgt);
        for (int c = 0; c < 2 * K_DONE && !(m_active && m_k == tgt); c++) @(negedge clk);
        check({name, "_reached"}, m_k, tgt, tgt);
    endtask

    task automatic set_range(input int lo, input int hi);
        for (int i = 0; i < N; i++) begin
            exp_lo[i] = lo;
            exp_hi[i] = hi;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        set_range(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel", 32'(sel), 0, 0);
        check("rst_cnt_out", 32'(cnt_out), 0, 0);
        check("rst_cnt_idx", 32'(cnt_idx), 0, 0);
        check("rst_cnt_valid", 32'(cnt_valid), 0, 0);
        check("rst_busy", 32'(busy), 0, 0);
        check("rst_done", 32'(done), 0, 0);
        check("rst_counter", 32'(dut.counter), 0, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Per-RO frequency: count within one of floor(G / period).
        mode = 2'd0;
        for (int i = 0; i < N; i++) begin
            exp_lo[i] = G / (4 + 2 * i) - 1;
            exp_hi[i] = G / (4 + 2 * i) + 1;
        end
        run_scan("freq");
        check("freq_idx0_literal", first_cnt, 24, 26);

        // Static inputs: nothing to count, scan length unchanged.
        set_range(0, 0);
        mode = 2'd1;
        run_scan("tie0");
        mode = 2'd2;
        repeat (5) @(negedge clk);
        run_scan("tie1");

        // start mid-gate of index 3 and during DONE is ignored.
        mode = 2'd0;
        for (int i = 0; i < N; i++) begin
            exp_lo[i] = G / (4 + 2 * i) - 1;
            exp_hi[i] = G / (4 + 2 * i) + 1;
        end
        snap();
        pulse_start();
        wait_k("ign_gate", 3 * L + S + 10);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_k("ign_done", K_DONE);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        check("ign_strobes", tot_strobes - s0, 8, 8);
        check("ign_dones", tot_dones - d0, 1, 1);
        check("ign_idle_busy", 32'(busy), 0, 0);

        // Reset in the gate window of index 5: clean abort, then a full fresh scan.
        snap();
        pulse_start();
        wait_k("rst_mid", 5 * L + S + 50);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0, 0);
        check("abort_sel", 32'(sel), 0, 0);
        check("abort_cnt_out", 32'(cnt_out), 0, 0);
        check("abort_cnt_valid", 32'(cnt_valid), 0, 0);
        check("abort_done", 32'(done), 0, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_strobes", tot_strobes - s0, 5, 5);
        check("abort_dones", tot_dones - d0, 0, 0);
        check("abort_sat_strobes", tot_strobes2 - s20, 5, 5);
        run_scan("after_rst");

        // clk/2 boundary: one edge every other cycle.
        mode = 2'd3;
        set_range(G / 2 - 1, G / 2 + 1);
        run_scan("half_clk");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
